// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with a power-of-two TX FIFO in front of it.
// Queued words go out back-to-back; the serial pin is driven from a register.
module uart_tx_param #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          tx_byte,
    input  logic                          tx_en,
    output logic                          tx_ready,
    output logic                          tx_busy,
    output logic                          tx_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          tx_pin
);

    localparam int unsigned BAUD_W  = $clog2(CLKS_PER_BIT);
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned BIT_W   = $clog2(DATA_BITS);
    localparam bit          PAR_ODD = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [BAUD_W-1:0]    baud_q, baud_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 pin_q, pin_d;
    logic                 busy_q;
    logic                 ready_q;
    logic                 ovf_q;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [PTR_W-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

    logic push, pop, bit_end, not_empty;

    // Storage has no reset: contents are don't-care once the pointers clear.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= tx_byte;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            pin_q   <= 1'b1;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            ovf_q   <= 1'b0;
            count_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            pin_q   <= pin_d;
            busy_q  <= (state_d != S_IDLE);
            ready_q <= (count_d < CNT_W'(FIFO_DEPTH));
            ovf_q   <= tx_en && !ready_q;
            count_q <= count_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
        end
    end

    // Next-state logic; pin_d is the value the line takes after this edge.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_d     = par_q;
        pin_d     = pin_q;
        pop       = 1'b0;
        push      = tx_en && ready_q;
        not_empty = (count_q != '0);
        bit_end   = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

        case (state_q)
            S_IDLE: begin
                pin_d = 1'b1;
                pop   = not_empty;
            end
            S_START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                    pin_d   = shift_q[0];
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                        bit_d = '0;
                        if (PARITY != 0) begin
                            state_d = S_PARITY;
                            pin_d   = par_q;
                        end else begin
                            state_d = S_STOP;
                            pin_d   = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        shift_d = shift_q >> 1;
                        pin_d   = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_STOP;
                    pin_d   = 1'b1;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_STOP: begin
                pin_d = 1'b1;
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                        pop     = not_empty;
                        state_d = S_IDLE;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                pin_d   = 1'b1;
            end
        endcase

        // Loading a frame overrides the IDLE/STOP choices above.
        if (pop) begin
            shift_d = mem_q[rd_q];
            par_d   = (^mem_q[rd_q]) ^ PAR_ODD;
            state_d = S_START;
            baud_d  = '0;
            bit_d   = '0;
            pin_d   = 1'b0;
        end

        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        wr_d    = push ? wr_q + PTR_W'(1) : wr_q;
        rd_d    = pop  ? rd_q + PTR_W'(1) : rd_q;
    end

    assign tx_pin      = pin_q;
    assign tx_busy     = busy_q;
    assign tx_ready    = ready_q;
    assign tx_overflow = ovf_q;
    assign fifo_count  = count_q;

endmodule
